axis_rx_pkt_buffer: RTL and testbench

//  Store-and-forward packet buffer on the 64-bit AXIS network receive path. It sits between
//  the MAC RX stream and the from_net_* input of the KVS block diagram.

---
 rtl/axis_rx_pkt_buffer_if.sv | 16 +
 rtl/axis_rx_pkt_buffer.sv | 174 +++++++++++++++++
 tb/tb_axis_rx_pkt_buffer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rx_pkt_buffer_if.sv
// AXI4-Stream bundle for the 64-bit network receive path; tuser carries per-beat sideband.
interface axis_rx_pkt_buffer_if;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned KEEP_W = 8;
   localparam int unsigned USER_W = 64;

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_rx_pkt_buffer.sv
// Store-and-forward RX packet buffer: forwards only complete error-free frames,
// never stalls the MAC, drops and counts frames that overflow or carry a MAC error.
module axis_rx_pkt_buffer #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned CNT_W = 32
) (
   input  logic                    clk_390,
   input  logic                    clk_390_rst_n,
   axis_rx_pkt_buffer_if.slave     s_axis,
   axis_rx_pkt_buffer_if.master    m_axis,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic [CNT_W-1:0]        fwd_cnt,
   output logic [$clog2(DEPTH):0]  occupancy
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   typedef struct packed {
      logic [63:0] tuser;
      logic        tlast;
      logic [7:0]  tkeep;
      logic [63:0] tdata;
   } word_t;

   typedef enum logic [1:0] {IDLE, WRITE, DROP} state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, raddr_q, raddr_d;
   logic [PTR_W-1:0] occ_q;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, fwd_cnt_q, fwd_cnt_d;
   logic             rdy_q;

   word_t            mem [DEPTH];
   word_t            s_word, rdata_q;
   word_t            out_q, out_d, sk_q, sk_d;
   logic             pipe_vld_q, out_vld_q, out_vld_d, sk_vld_q, sk_vld_d;
   logic             beat, full, mem_we, rd_issue, pop;
   logic [1:0]       stage_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign beat   = s_axis.tvalid & rdy_q;
   assign full   = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
   assign s_word = {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};

   // Write FSM: speculative wr_ptr, published through wr_commit only on a good tlast.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      drop_cnt_d  = drop_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      mem_we      = 1'b0;
      unique case (state_q)
         IDLE, WRITE: begin
            if (beat) begin
               if (!full) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  if (s_axis.tlast) begin
                     state_d = IDLE;
                     if (!s_axis.tuser[0]) begin
                        wr_commit_d = wr_ptr_q + PTR_W'(1);
                        fwd_cnt_d   = sat_inc(fwd_cnt_q);
                     end else begin
                        wr_ptr_d   = wr_commit_q;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                     end
                  end else begin
                     state_d = WRITE;
                  end
               end else begin
                  wr_ptr_d = wr_commit_q;
                  if (s_axis.tlast) begin
                     state_d    = IDLE;
                     drop_cnt_d = sat_inc(drop_cnt_q);
                  end else begin
                     state_d = DROP;
                  end
               end
            end
         end
         DROP: begin
            if (beat && s_axis.tlast) begin
               state_d    = IDLE;
               drop_cnt_d = sat_inc(drop_cnt_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read side: one RAM read stage feeding a 2-entry output/skid pair; the RAM slot is
   // only released (rd_ptr) when the word is actually accepted downstream.
   always_comb begin
      pop       = out_vld_q & m_axis.tready;
      stage_cnt = 2'(out_vld_q) + 2'(sk_vld_q) + 2'(pipe_vld_q) - 2'(pop);
      rd_issue  = (raddr_q != wr_commit_q) && (stage_cnt < 2'd2);
      raddr_d   = rd_issue ? raddr_q + PTR_W'(1) : raddr_q;
      rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      out_d     = out_q;
      out_vld_d = out_vld_q;
      sk_d      = sk_q;
      sk_vld_d  = sk_vld_q;
      if (!out_vld_q || pop) begin
         if (sk_vld_q) begin
            out_d     = sk_q;
            out_vld_d = 1'b1;
            sk_vld_d  = pipe_vld_q;
            if (pipe_vld_q) sk_d = rdata_q;
         end else if (pipe_vld_q) begin
            out_d     = rdata_q;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (pipe_vld_q) begin
         sk_d     = rdata_q;
         sk_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_390) begin
      if (mem_we)   mem[wr_ptr_q[ADDR_W-1:0]] <= s_word;
      if (rd_issue) rdata_q <= mem[raddr_q[ADDR_W-1:0]];
   end

   always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
      if (!clk_390_rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         raddr_q     <= '0;
         occ_q       <= '0;
         drop_cnt_q  <= '0;
         fwd_cnt_q   <= '0;
         rdy_q       <= 1'b0;
         pipe_vld_q  <= 1'b0;
         out_vld_q   <= 1'b0;
         out_q       <= '0;
         sk_vld_q    <= 1'b0;
         sk_q        <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         raddr_q     <= raddr_d;
         occ_q       <= wr_ptr_d - rd_ptr_d;
         drop_cnt_q  <= drop_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
         rdy_q       <= 1'b1;
         pipe_vld_q  <= rd_issue;
         out_vld_q   <= out_vld_d;
         out_q       <= out_d;
         sk_vld_q    <= sk_vld_d;
         sk_q        <= sk_d;
      end
   end

   assign s_axis.tready = rdy_q;
   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tdata  = out_q.tdata;
   assign m_axis.tkeep  = out_q.tkeep;
   assign m_axis.tuser  = out_q.tuser;
   assign m_axis.tlast  = out_q.tlast;
   assign drop_cnt      = drop_cnt_q;
   assign fwd_cnt       = fwd_cnt_q;
   assign occupancy     = occ_q;
endmodule

// File: tb/tb_axis_rx_pkt_buffer.sv
// Bench for axis_rx_pkt_buffer: frame-level reference model feeding a scoreboard queue,
// separate output monitor, directed scenarios plus randomized traffic and back-pressure.
module tb_axis_rx_pkt_buffer;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [63:0] tuser;
      logic        tlast;
      logic [7:0]  tkeep;
      logic [63:0] tdata;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [CNT_W-1:0] drop_cnt, fwd_cnt;
   logic [OCC_W-1:0] occupancy;

   axis_rx_pkt_buffer_if s_if ();
   axis_rx_pkt_buffer_if m_if ();

   axis_rx_pkt_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_390       (clk),
      .clk_390_rst_n (rst_n),
      .s_axis        (s_if.slave),
      .m_axis        (m_if.master),
      .drop_cnt      (drop_cnt),
      .fwd_cnt       (fwd_cnt),
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   int    total = 0;
   int    bad   = 0;
   int    tready_mode = 1;   // 0 = stall, 1 = always ready, 2 = random 50%
   word_t exp_q[$];
   word_t cur_q[$];
   int    held = 0;
   bit    dropping = 1'b0;
   int    exp_drop = 0;
   int    exp_fwd  = 0;
   word_t mw, mon_w, prev_w;
   bit    prev_stall = 1'b0;
   int    lat;
   bit    found;

   task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (tready_mode == 2) m_if.tready = 1'($urandom_range(0, 1));
      else                  m_if.tready = (tready_mode == 1);
   end

   // Reference model: frame-level accounting of buffer space, commits and drops.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         cur_q.delete();
         held     = 0;
         dropping = 1'b0;
         exp_drop = 0;
         exp_fwd  = 0;
      end else begin
         check("occupancy", occupancy, held + cur_q.size());
         check("drop_cnt", drop_cnt, exp_drop);
         check("fwd_cnt", fwd_cnt, exp_fwd);
         if (s_if.tvalid) begin
            check("s_tready", s_if.tready, 1);
            mw = {s_if.tuser, s_if.tlast, s_if.tkeep, s_if.tdata};
            if (dropping) begin
               if (mw.tlast) begin
                  exp_drop++;
                  dropping = 1'b0;
               end
            end else if (held + cur_q.size() >= int'(DEPTH)) begin
               cur_q.delete();
               if (mw.tlast) exp_drop++;
               else          dropping = 1'b1;
            end else begin
               cur_q.push_back(mw);
               if (mw.tlast) begin
                  if (mw.tuser[0]) begin
                     exp_drop++;
                  end else begin
                     foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                     held += cur_q.size();
                     exp_fwd++;
                  end
                  cur_q.delete();
               end
            end
         end
         if (m_if.tvalid && m_if.tready) held--;
      end
   end

   // Output monitor: scoreboard pop on each handshake, plus hold-while-stalled check.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         mon_w = {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
         if (prev_stall) begin
            check("stall_valid", m_if.tvalid, 1);
            check("stall_hold", mon_w, prev_w);
         end
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected: got %0h expected none at %0t", mon_w, $time);
            end else begin
               check("out_word", mon_w, exp_q.pop_front());
            end
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_w     = mon_w;
      end
   end

   task automatic send_frame(input int len, input bit err);
      logic [63:0] u;
      for (int i = 0; i < len; i++) begin
         u = {$urandom, $urandom};
         if (i == len - 1) u[0] = err;
         s_if.tdata  = {$urandom, $urandom};
         s_if.tkeep  = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
         s_if.tuser  = u;
         s_if.tlast  = (i == len - 1);
         s_if.tvalid = 1'b1;
         @(posedge clk);
         #1;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 2000 && (exp_q.size() != 0); k++) @(posedge clk);
      check("drain_queue", exp_q.size(), 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("drain_idle", m_if.tvalid, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tuser  = '0;

      // reset values and tready rising one edge after release
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", s_if.tready, 0);
      check("rst_m_tvalid", m_if.tvalid, 0);
      check("rst_m_tlast", m_if.tlast, 0);
      check("rst_m_tdata", m_if.tdata, 0);
      check("rst_m_tkeep", m_if.tkeep, 0);
      check("rst_m_tuser", m_if.tuser, 0);
      check("rst_occ", occupancy, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_fwd", fwd_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("tready_before_edge", s_if.tready, 0);
      @(negedge clk);
      check("tready_after_edge", s_if.tready, 1);
      @(posedge clk);
      #1;

      // 1: single good 3-beat frame, latency of first output beat
      tready_mode = 1;
      send_frame(3, 1'b0);
      found = 1'b0;
      lat   = -1;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (m_if.tvalid) begin
            found = 1'b1;
            lat   = k;
         end
         @(posedge clk);
      end
      #1;
      check("t1_latency", lat, 2);
      wait_drain();
      check("t1_fwd", fwd_cnt, 1);
      check("t1_drop", drop_cnt, 0);

      // 2: errored frame dropped, following good frame forwarded
      apply_reset();
      send_frame(2, 1'b1);
      send_frame(1, 1'b0);
      wait_drain();
      check("t2_drop", drop_cnt, 1);
      check("t2_fwd", fwd_cnt, 1);

      // 3: overflow with output stalled
      apply_reset();
      tready_mode = 0;
      send_frame(5, 1'b0);
      send_frame(5, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t3_drop", drop_cnt, 1);
      check("t3_occ", occupancy, 5);
      @(posedge clk);
      #1;
      tready_mode = 1;
      wait_drain();
      check("t3_occ_empty", occupancy, 0);

      // 4: frame longer than the buffer
      apply_reset();
      send_frame(9, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t4_drop", drop_cnt, 1);
      check("t4_occ", occupancy, 0);
      check("t4_fwd", fwd_cnt, 0);
      check("t4_no_out", m_if.tvalid, 0);
      @(posedge clk);
      #1;

      // 5: back-to-back full-size frames, then random lengths/gaps, random back-pressure
      apply_reset();
      tready_mode = 2;
      repeat (20) send_frame(8, ($urandom_range(0, 7) == 0));
      repeat (40) begin
         send_frame($urandom_range(1, 10), ($urandom_range(0, 5) == 0));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      tready_mode = 1;
      wait_drain();

      // 6: asynchronous reset while output is active
      apply_reset();
      tready_mode = 1;
      send_frame(6, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (m_if.tvalid) found = 1'b1;
      end
      check("t6_output_seen", found, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_async_tvalid", m_if.tvalid, 0);
      check("t6_async_occ", occupancy, 0);
      check("t6_async_fwd", fwd_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_occ", occupancy, 0);
      check("t6_drop", drop_cnt, 0);
      check("t6_fwd", fwd_cnt, 0);
      check("t6_no_stale", m_if.tvalid, 0);
      @(posedge clk);
      #1;
      send_frame(3, 1'b0);
      wait_drain();
      check("t6_fwd_after", fwd_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
